// File: rtl/case_pkg.sv
// Shared definitions for the case-conversion stream: mode encodings,
// ASCII letter bounds and the bit that distinguishes upper from lower case.
package case_pkg;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'b00,
      MODE_UPPER  = 2'b01,
      MODE_LOWER  = 2'b10,
      MODE_TOGGLE = 2'b11
   } mode_e;

   localparam logic [7:0] ASCII_A  = 8'd65;
   localparam logic [7:0] ASCII_Z  = 8'd90;
   localparam logic [7:0] ASCII_LA = 8'd97;
   localparam logic [7:0] ASCII_LZ = 8'd122;

   localparam int unsigned CASE_BIT  = 5;
   localparam logic [7:0]  CASE_MASK = 8'(1 << CASE_BIT);

endpackage

// File: rtl/case_convert_lane.sv
// One-byte combinational case converter. Only ASCII letters are touched;
// a disabled lane passes through and never reports a change.
module case_convert_lane
   import case_pkg::*;
(
   input  logic [7:0] i_byte,
   input  mode_e      i_mode,
   input  logic       i_keep,
   output logic [7:0] o_byte,
   output logic       o_changed
);

   logic w_is_upper;
   logic w_is_lower;

   assign w_is_upper = (i_byte >= ASCII_A)  && (i_byte <= ASCII_Z);
   assign w_is_lower = (i_byte >= ASCII_LA) && (i_byte <= ASCII_LZ);

   // Flip the case bit only when the mode targets this byte's letter class
   always_comb begin
      o_byte = i_byte;
      if (i_keep) begin
         case (i_mode)
            MODE_UPPER:  if (w_is_lower) o_byte = i_byte ^ CASE_MASK;
            MODE_LOWER:  if (w_is_upper) o_byte = i_byte ^ CASE_MASK;
            MODE_TOGGLE: if (w_is_upper || w_is_lower) o_byte = i_byte ^ CASE_MASK;
            default:     o_byte = i_byte;
         endcase
      end
   end

   assign o_changed = i_keep && (o_byte != i_byte);

endmodule

// File: rtl/case_convert_stream.sv
// Multi-lane case converter with a one-deep output register slice
// (full throughput) and a saturating count of converted bytes.
module case_convert_stream
   import case_pkg::*;
#(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*LANES-1:0]   in_data,
   input  logic [LANES-1:0]     in_keep,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_data,
   output logic [LANES-1:0]     out_keep,
   output logic                 out_last,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     conv_count
);

   localparam int POP_W = $clog2(LANES + 1);
   localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [8*LANES-1:0] w_conv_data;
   logic [LANES-1:0]   w_changed;
   logic [POP_W-1:0]   w_pop;
   logic [SUM_W-1:0]   w_sum;
   logic [CNT_W-1:0]   w_count_next;
   logic               w_accept;

   logic               r_out_valid;
   logic [8*LANES-1:0] r_out_data;
   logic [LANES-1:0]   r_out_keep;
   logic               r_out_last;
   logic [CNT_W-1:0]   r_count;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         case_convert_lane u_lane (
            .i_byte    (in_data[8*gi +: 8]),
            .i_mode    (mode_e'(mode)),
            .i_keep    (in_keep[gi]),
            .o_byte    (w_conv_data[8*gi +: 8]),
            .o_changed (w_changed[gi])
         );
      end
   endgenerate

   // The slice can take a beat when empty or when its beat drains this cycle
   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   // Count how many lanes of the incoming beat were actually changed
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < LANES; i++) begin
         w_pop = w_pop + POP_W'(w_changed[i]);
      end
   end

   // Widened add so the saturation test cannot wrap
   assign w_sum        = SUM_W'(r_count) + SUM_W'(w_pop);
   assign w_count_next = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

   // Output register slice: load on accept, drop valid when drained
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_keep  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_conv_data;
         r_out_keep  <= in_keep;
         r_out_last  <= in_last;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Saturating converted-byte counter; clear beats a simultaneous increment
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_count <= '0;
      end else if (w_accept) begin
         r_count <= w_count_next;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_keep   = r_out_keep;
   assign out_last   = r_out_last;
   assign conv_count = r_count;

endmodule

// File: tb/tb_case_convert_stream.sv
// Directed bench for case_convert_stream: a 16-bit-counter instance for the
// datapath scenarios and a 4-bit-counter instance for saturation.
module tb_case_convert_stream;

   logic        clk;
   logic        rst;
   logic [1:0]  mode;
   logic        in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_keep;
   logic        in_last;
   logic        out_ready;
   logic        cnt_clr;

   logic        a_in_ready, a_out_valid, a_out_last;
   logic [31:0] a_out_data;
   logic [3:0]  a_out_keep;
   logic [15:0] a_count;

   logic        b_in_ready, b_out_valid, b_out_last;
   logic [31:0] b_out_data;
   logic [3:0]  b_out_keep;
   logic [3:0]  b_count;

   int n_checks;
   int n_fail;

   case_convert_stream #(.LANES(4), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .mode(mode),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .in_keep(in_keep), .in_last(in_last),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .out_keep(a_out_keep), .out_last(a_out_last),
      .cnt_clr(cnt_clr), .conv_count(a_count)
   );

   case_convert_stream #(.LANES(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .mode(mode),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .in_keep(in_keep), .in_last(in_last),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .out_keep(b_out_keep), .out_last(b_out_last),
      .cnt_clr(cnt_clr), .conv_count(b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   // Present one beat for one edge, then withdraw it; outputs settled on return
   task automatic send(input logic [1:0] m, input logic [31:0] d, input logic [3:0] k,
                       input logic l);
      mode     = m;
      in_data  = d;
      in_keep  = k;
      in_last  = l;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      mode      = 2'b00;
      in_valid  = 1'b0;
      in_data   = '0;
      in_keep   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      cnt_clr   = 1'b0;
      idle_cycle();
      idle_cycle();
      rst = 1'b0;
      idle_cycle();

      // reset state
      check("rst_valid", 32'(a_out_valid), 32'd0);
      check("rst_data",  a_out_data, 32'h0);
      check("rst_keep",  32'(a_out_keep), 32'h0);
      check("rst_last",  32'(a_out_last), 32'd0);
      check("rst_count", 32'(a_count), 32'd0);
      check("rst_ready", 32'(a_in_ready), 32'd1);

      // 1: UPPER
      out_ready = 1'b1;
      send(2'b01, 32'h7B7A6140, 4'hF, 1'b0);
      check("s1_valid", 32'(a_out_valid), 32'd1);
      check("s1_data",  a_out_data, 32'h7B5A4140);
      check("s1_count", 32'(a_count), 32'd2);

      // 2: LOWER then TOGGLE
      send(2'b10, 32'h5B5A4140, 4'hF, 1'b0);
      check("s2_lower_data",  a_out_data, 32'h5B7A6140);
      check("s2_lower_count", 32'(a_count), 32'd4);
      send(2'b11, 32'h83B76148, 4'hF, 1'b0);
      check("s2_toggle_data",  a_out_data, 32'h83B74168);
      check("s2_toggle_count", 32'(a_count), 32'd6);

      // 3: partial keep, then PASS
      send(2'b01, 32'h61616161, 4'b0101, 1'b0);
      check("s3_keep_data",  a_out_data, 32'h61416141);
      check("s3_keep_keep",  32'(a_out_keep), 32'h5);
      check("s3_keep_count", 32'(a_count), 32'd8);
      send(2'b00, 32'h61616161, 4'hF, 1'b0);
      check("s3_pass_data",  a_out_data, 32'h61616161);
      check("s3_pass_count", 32'(a_count), 32'd8);
      idle_cycle();
      check("s3_drained", 32'(a_out_valid), 32'd0);

      // 4: backpressure with two back-to-back beats
      send(2'b01, 32'h61626364, 4'hF, 1'b0);
      check("s4_b1_data", a_out_data, 32'h41424344);
      check("s4_b1_last", 32'(a_out_last), 32'd0);
      out_ready = 1'b0;
      mode      = 2'b01;
      in_data   = 32'h65666768;
      in_keep   = 4'hF;
      in_last   = 1'b1;
      in_valid  = 1'b1;
      #1;
      check("s4_ready_low", 32'(a_in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("s4_stall%0d_ready", i), 32'(a_in_ready), 32'd0);
         check($sformatf("s4_stall%0d_valid", i), 32'(a_out_valid), 32'd1);
         check($sformatf("s4_stall%0d_data", i), a_out_data, 32'h41424344);
         check($sformatf("s4_stall%0d_last", i), 32'(a_out_last), 32'd0);
      end
      check("s4_stall_count", 32'(a_count), 32'd12);
      out_ready = 1'b1;
      #1;
      check("s4_ready_rel", 32'(a_in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("s4_b2_valid", 32'(a_out_valid), 32'd1);
      check("s4_b2_data",  a_out_data, 32'h45464748);
      check("s4_b2_last",  32'(a_out_last), 32'd1);
      check("s4_b2_count", 32'(a_count), 32'd16);
      idle_cycle();
      check("s4_no_dup", 32'(a_out_valid), 32'd0);

      // 5: saturation on the 4-bit counter, then clear with a beat
      cnt_clr = 1'b1;
      idle_cycle();
      cnt_clr = 1'b0;
      check("s5_clr_a", 32'(a_count), 32'd0);
      check("s5_clr_b", 32'(b_count), 32'd0);
      send(2'b01, 32'h61626364, 4'hF, 1'b0);
      check("s5_beat1", 32'(b_count), 32'd4);
      send(2'b01, 32'h61626364, 4'hF, 1'b0);
      check("s5_beat2", 32'(b_count), 32'd8);
      send(2'b01, 32'h61626364, 4'hF, 1'b0);
      check("s5_beat3", 32'(b_count), 32'd12);
      send(2'b01, 32'h61626364, 4'hF, 1'b0);
      check("s5_beat4", 32'(b_count), 32'd15);
      send(2'b01, 32'h61626364, 4'hF, 1'b0);
      check("s5_beat5", 32'(b_count), 32'd15);
      check("s5_a_count", 32'(a_count), 32'd20);
      cnt_clr = 1'b1;
      send(2'b01, 32'h61626364, 4'hF, 1'b0);
      cnt_clr = 1'b0;
      check("s5_clr_beat_b", 32'(b_count), 32'd0);
      check("s5_clr_beat_a", 32'(a_count), 32'd0);
      check("s5_clr_beat_data", b_out_data, 32'h41424344);
      idle_cycle();

      // 6: reset while a beat is held
      out_ready = 1'b0;
      send(2'b01, 32'h61626364, 4'hF, 1'b1);
      check("s6_held_valid", 32'(a_out_valid), 32'd1);
      rst = 1'b1;
      idle_cycle();
      rst = 1'b0;
      check("s6_rst_valid", 32'(a_out_valid), 32'd0);
      check("s6_rst_data",  a_out_data, 32'h0);
      check("s6_rst_keep",  32'(a_out_keep), 32'h0);
      check("s6_rst_last",  32'(a_out_last), 32'd0);
      check("s6_rst_count", 32'(a_count), 32'd0);
      check("s6_rst_ready", 32'(a_in_ready), 32'd1);
      out_ready = 1'b1;
      send(2'b10, 32'h41424344, 4'hF, 1'b0);
      check("s6_after_valid", 32'(a_out_valid), 32'd1);
      check("s6_after_data",  a_out_data, 32'h61626364);
      check("s6_after_count", 32'(a_count), 32'd4);
      idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/case_convert_stream.md
# case_convert_stream

Parametrised, pipelined successor to the combinational ASCII upper-casing block. It converts a multi-byte character stream between letter cases under a runtime-selectable mode, with valid/ready flow control, per-lane byte enables and a saturating count of converted characters. It sits in the text-processing datapath between a byte-stream source and any downstream consumer that needs case-normalised ASCII.

## Interface
- `LANES`, 4: bytes per beat; lane k occupies bits [8k+7:8k]; must be ≥1
- `CNT_W`, 16: width of the converted-character counter; must be ≥1
- `clk` input 1: sole clock, rising edge
- `rst` input 1: reset, synchronous, active-high
- `mode` input 2: conversion mode, sampled on input acceptance
- `in_valid` input 1: input beat present
- `in_ready` output 1: block can accept a beat
- `in_data` input 8*LANES: input characters
- `in_keep` input LANES: lane enables; a 0 lane passes unchanged and is not counted
- `in_last` input 1: end-of-message marker, carried through
- `out_valid` output 1: output beat present
- `out_ready` input 1: consumer accepts the beat
- `out_data` output 8*LANES: converted characters
- `out_keep` output LANES: registered copy of `in_keep`
- `out_last` output 1: registered copy of `in_last`
- `cnt_clr` input 1: synchronous clear of `conv_count`
- `conv_count` output CNT_W: number of bytes changed since reset or clear

## Operation
- Modes: 00 PASS (no change); 01 UPPER ('a'..'z', 97–122, clear bit 5); 10 LOWER ('A'..'Z', 65–90, set bit 5); 11 TOGGLE (flip bit 5 of letters only).
- All other bytes, including 128–255, pass unchanged in every mode.
- A byte counts as converted only if its lane is enabled and its output differs from its input. PASS never counts.
- Accept: `in_valid && in_ready`. Conversion uses `mode` in the accept cycle. A mode change while a beat waits in the output register does not affect that beat.
- Output register slice: `in_ready = !out_valid || out_ready`. This gives full throughput: a new beat is accepted in the same cycle the held beat drains.
- Held beat: while `out_valid && !out_ready`, `out_data`, `out_keep` and `out_last` hold stable.
- `conv_count` adds the converted-byte count of each accepted beat in the accept cycle and saturates at 2^CNT_W−1.
- `cnt_clr` forces the count to 0 and takes priority over a simultaneous increment; that beat's conversions are discarded.

## Timing
- Latency 1 cycle: a beat accepted at edge n is valid on `out_*` after edge n.
- `conv_count` updates at the same edge as acceptance.
- Reset, synchronous: `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0, `conv_count`=0. `in_ready` reads 1 in the cycle after reset.
- Reset mid-operation discards any held beat; no partial beat is emitted.
- `in_ready` depends combinationally on `out_ready`. No other input-to-output combinational paths exist.

## Structure
- Package `case_pkg`:
  - mode encodings `MODE_PASS`, `MODE_UPPER`, `MODE_LOWER`, `MODE_TOGGLE`
  - ASCII bounds `ASCII_A`=65, `ASCII_Z`=90, `ASCII_LA`=97, `ASCII_LZ`=122
  - `CASE_BIT`=5
- Sub-module `case_convert_lane`: combinational, one byte. Inputs: byte, mode, keep. Outputs: converted byte, changed flag. Instantiated LANES times via generate.
- Top level holds the register slice, a popcount of the changed flags, and the saturating counter.

## Test plan
All scenarios use LANES=4.
1. UPPER, `in_data`=32'h7B7A6140 ('@','a','z','{'), keep F, `out_ready`=1 -> `out_data`=32'h7B5A4140 one cycle later; `conv_count`=2.
2. LOWER, then TOGGLE:
   - LOWER, 32'h5B5A4140 -> 32'h5B7A6140; count +2.
   - TOGGLE, 32'h83B76148 -> 32'h83B74168; count +2; high bytes untouched.
3. UPPER, 32'h61616161, keep 4'b0101 -> 32'h61416141, `out_keep`=0101, count +2. PASS beat of the same data -> unchanged, count +0.
4. Backpressure:
   - Two back-to-back beats with `out_last` on the second; `out_ready` low for 3 cycles after the first is captured.
   - Required: `in_ready`=0 and `out_data` stable while stalled.
   - On release: both beats delivered in order, no loss or duplication, `out_last` only on the second.
5. CNT_W=4, UPPER:
   - Five beats of 32'h61626364 -> count 4, 8, 12, 15, 15 (saturates).
   - `cnt_clr` together with a sixth beat -> count 0.
6. Assert `rst` while a beat is held with `out_ready`=0 -> next cycle all outputs are reset values; the following beat flows with latency 1.
